reg_writeback: RTL and testbench

//   Write-back unit driving the register-file write port (WB_addr/WB_data/RegWe).

---
 rtl/reg_writeback.sv | 154 +++++++++++++++
 tb/tb_reg_writeback.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file write-back stage: merges single-cycle ALU results with buffered
// memory load returns and tracks which registers still await a load.
module reg_writeback #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_addr,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic [AW-1:0]     WB_addr,
    output logic [DW-1:0]     WB_data,
    output logic              RegWe,
    output logic [2**AW-1:0]  pending,
    output logic              hazard_err
);

    localparam int NREG = 2**AW;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            r_fifo [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [AW-1:0]     r_wb_addr;
    logic [DW-1:0]     r_wb_data;
    logic              r_reg_we;
    logic [NREG-1:0]   r_pending;
    logic              r_hazard;

    logic              w_full;
    logic              w_empty;
    logic              w_alu_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_hazard;
    entry_t            w_head;
    logic [NREG-1:0]   w_pending_next;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head    = r_fifo[r_rd_ptr];

    // A flush cancels every same-cycle request; ALU writes to r0 free the port for the FIFO.
    assign w_alu_wr  = !clear && alu_valid && (alu_addr != '0);
    assign w_push    = !clear && mem_valid && !w_full;
    assign w_pop     = !clear && !w_alu_wr && !w_empty;
    assign w_hazard  = w_alu_wr && r_pending[alu_addr];

    assign mem_ready  = !w_full;
    assign WB_addr    = r_wb_addr;
    assign WB_data    = r_wb_data;
    assign RegWe      = r_reg_we;
    assign pending    = r_pending;
    assign hazard_err = r_hazard;

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_pending_next = r_pending;
        if (w_pop) begin
            w_pending_next[w_head.addr] = 1'b0;
        end
        // Applied after the pop clear so a same-cycle set wins.
        if (ld_issue && (ld_addr != '0)) begin
            w_pending_next[ld_addr] = 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: mem_addr, data: mem_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_reg_we  <= 1'b0;
        end else if (w_alu_wr) begin
            r_wb_addr <= alu_addr;
            r_wb_data <= alu_data;
            r_reg_we  <= 1'b1;
        end else if (w_pop && (w_head.addr != '0)) begin
            r_wb_addr <= w_head.addr;
            r_wb_data <= w_head.data;
            r_reg_we  <= 1'b1;
        end else begin
            r_reg_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (clear) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Sticky until reset; a flush does not hide a past hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazard <= 1'b0;
        end else if (w_hazard) begin
            r_hazard <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback: ALU/load arbitration, FIFO
// ordering and full handling, scoreboard, hazard flag, flush and async reset.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [2:0]  ld_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic [2:0]  WB_addr;
    logic [15:0] WB_data;
    logic        RegWe;
    logic [7:0]  pending;
    logic        hazard_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DW(16), .AW(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_issue   (ld_issue),
        .ld_addr    (ld_addr),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .WB_addr    (WB_addr),
        .WB_data    (WB_data),
        .RegWe      (RegWe),
        .pending    (pending),
        .hazard_err (hazard_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_issue  = 1'b0;
        ld_addr   = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
        check({tag, ".we"}, 32'(RegWe), 32'(we));
        check({tag, ".addr"}, 32'(WB_addr), 32'(a));
        check({tag, ".data"}, 32'(WB_data), 32'(d));
    endtask

    initial begin
        logic [2:0]  push_addr [4];
        logic [15:0] push_data [4];
        push_addr = '{3'd4, 3'd6, 3'd7, 3'd1};
        push_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_wb("reset", 1'b0, 3'd0, 16'h0000);
        check("reset.pending", 32'(pending), 32'h00);
        check("reset.hazard", 32'(hazard_err), 32'h0);
        check("reset.ready", 32'(mem_ready), 32'h1);
        rst_n = 1'b1;
        cyc();

        // 1: single ALU write, one-cycle latency, one-cycle RegWe
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234;
        cyc();
        check_wb("t1.write", 1'b1, 3'd3, 16'h1234);
        alu_valid = 1'b0;
        cyc();
        check_wb("t1.after", 1'b0, 3'd3, 16'h1234);

        // 2: load to r5, pending until its write-back
        ld_issue = 1'b1; ld_addr = 3'd5;
        cyc();
        check("t2.pend_set", 32'(pending), 32'h20);
        ld_issue = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'hBEEF;
        cyc();
        check("t2.pend_held", 32'(pending), 32'h20);
        check("t2.no_passthru", 32'(RegWe), 32'h0);
        mem_valid = 1'b0;
        cyc();
        check_wb("t2.write", 1'b1, 3'd5, 16'hBEEF);
        check("t2.pend_clr", 32'(pending), 32'h00);
        cyc();
        check("t2.idle", 32'(RegWe), 32'h0);

        // 3: fill the FIFO under continuous ALU traffic, then drain in order
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            check("t3.ready_before_push", 32'(mem_ready), 32'h1);
            mem_valid = 1'b1; mem_addr = push_addr[i]; mem_data = push_data[i];
            cyc();
            check_wb("t3.alu_wins", 1'b1, 3'd1, 16'h00AA);
        end
        check("t3.full", 32'(mem_ready), 32'h0);
        mem_addr = 3'd2; mem_data = 16'hDEAD;
        cyc();
        check("t3.still_full", 32'(mem_ready), 32'h0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_wb("t3.drain", 1'b1, push_addr[i], push_data[i]);
            check("t3.ready_after_pop", 32'(mem_ready), 32'h1);
        end
        cyc();
        check("t3.no_dropped_write", 32'(RegWe), 32'h0);

        // 4: ALU writes a register with a load outstanding
        ld_issue = 1'b1; ld_addr = 3'd2;
        cyc();
        check("t4.pend", 32'(pending), 32'h04);
        check("t4.no_hazard_yet", 32'(hazard_err), 32'h0);
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h5555;
        cyc();
        check_wb("t4.alu_write", 1'b1, 3'd2, 16'h5555);
        check("t4.hazard", 32'(hazard_err), 32'h1);
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h6666;
        cyc();
        check("t4.hazard_sticky", 32'(hazard_err), 32'h1);
        mem_valid = 1'b0;
        cyc();
        check_wb("t4.load_write", 1'b1, 3'd2, 16'h6666);
        check("t4.pend_clr", 32'(pending), 32'h00);

        // 5: flush with three buffered returns and pending = 2C
        ld_issue = 1'b1; ld_addr = 3'd2; cyc();
        ld_addr = 3'd3; cyc();
        ld_addr = 3'd5; cyc();
        ld_issue = 1'b0;
        check("t5.pend", 32'(pending), 32'h2C);
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0101;
        mem_valid = 1'b1;
        mem_addr = 3'd2; mem_data = 16'hA002; cyc();
        mem_addr = 3'd3; mem_data = 16'hA003; cyc();
        mem_addr = 3'd5; mem_data = 16'hA005; cyc();
        check("t5.pend_before_clear", 32'(pending), 32'h2C);
        check_wb("t5.inflight", 1'b1, 3'd1, 16'h0101);
        clear = 1'b1;
        ld_issue = 1'b1; ld_addr = 3'd6;
        mem_addr = 3'd7; mem_data = 16'hBAD0;
        cyc();
        check("t5.we", 32'(RegWe), 32'h0);
        check("t5.pend", 32'(pending), 32'h00);
        check("t5.ready", 32'(mem_ready), 32'h1);
        check("t5.hazard_kept", 32'(hazard_err), 32'h1);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5.no_stale", 32'(RegWe), 32'h0);
        end

        // 6: ALU to r0 frees the port for a buffered return; r0 loads never written
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0707;
        mem_valid = 1'b1; mem_addr = 3'd4; mem_data = 16'h4444;
        cyc();
        check_wb("t6.alu", 1'b1, 3'd1, 16'h0707);
        alu_addr = 3'd0; alu_data = 16'hFFFF;
        mem_valid = 1'b0;
        cyc();
        check_wb("t6.fifo_on_r0", 1'b1, 3'd4, 16'h4444);
        cyc();
        check_wb("t6.r0_discard", 1'b0, 3'd4, 16'h4444);
        alu_valid = 1'b0;
        ld_issue = 1'b1; ld_addr = 3'd0;
        mem_valid = 1'b1; mem_addr = 3'd0; mem_data = 16'h9999;
        cyc();
        check("t6.r0_no_pending", 32'(pending), 32'h00);
        idle_inputs();
        cyc();
        check_wb("t6.r0_load_dropped", 1'b0, 3'd4, 16'h4444);

        // async reset mid-operation discards an in-flight load
        ld_issue = 1'b1; ld_addr = 3'd6;
        cyc();
        ld_issue = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd6; mem_data = 16'h7777;
        cyc();
        mem_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_wb("rst.async", 1'b0, 3'd0, 16'h0000);
        check("rst.pending", 32'(pending), 32'h00);
        check("rst.hazard", 32'(hazard_err), 32'h0);
        check("rst.ready", 32'(mem_ready), 32'h1);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rst.load_lost", 32'(RegWe), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
